// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for a single memory port, one outstanding access at a time.
// Define ARB_RR_EN for round-robin tie-breaking; default is fixed LSU priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = DATA_W/8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e              state_q;
  logic                owner_q;      // 1 = LSU owns the in-flight access
  logic                req_valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic                ifu_resp_q, lsu_resp_q;
  logic [DATA_W-1:0]   ifu_rdata_q, lsu_rdata_q;
  logic                grant_lsu;
  logic                accept;

`ifdef ARB_RR_EN
  logic rr_q;  // last granted requester, 1 = LSU
  assign grant_lsu = lsu_req_valid && (!ifu_req_valid || !rr_q);
`else
  assign grant_lsu = lsu_req_valid;
`endif

  // Readies are combinational off the state; gated by rst so they read 0 while in reset.
  assign lsu_req_ready = rst && (state_q == IDLE) && grant_lsu;
  assign ifu_req_ready = rst && (state_q == IDLE) && !grant_lsu;
  assign accept        = (lsu_req_valid && lsu_req_ready) || (ifu_req_valid && ifu_req_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
`ifdef ARB_RR_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      ifu_resp_q <= 1'b0;
      lsu_resp_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          owner_q     <= grant_lsu;
          req_valid_q <= 1'b1;
          addr_q      <= grant_lsu ? lsu_addr : ifu_addr;
          wen_q       <= grant_lsu && lsu_wen;
          wdata_q     <= grant_lsu ? lsu_wdata : '0;
          wmask_q     <= (grant_lsu && lsu_wen) ? lsu_wmask : '0;
`ifdef ARB_RR_EN
          rr_q        <= grant_lsu;
`endif
          state_q     <= REQ;
        end
        REQ: if (mem_req_ready) begin
          req_valid_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: if (mem_resp_valid) begin
          if (owner_q) begin
            lsu_rdata_q <= mem_rdata;
            lsu_resp_q  <= 1'b1;
          end else begin
            ifu_rdata_q <= mem_rdata;
            ifu_resp_q  <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_valid  = req_valid_q;
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = ifu_resp_q;
  assign lsu_resp_valid = lsu_resp_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign lsu_rdata      = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration, handshakes, stalls, stray responses and mid-flight reset.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, MW = 4;

  logic          clk, rst;
  logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [MW-1:0] lsu_wmask;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ifu_ready"}, ifu_req_ready, 0);
    chk({tag, ".lsu_ready"}, lsu_req_ready, 0);
    chk({tag, ".ifu_resp"},  ifu_resp_valid, 0);
    chk({tag, ".lsu_resp"},  lsu_resp_valid, 0);
    chk({tag, ".ifu_rdata"}, ifu_rdata, 0);
    chk({tag, ".lsu_rdata"}, lsu_rdata, 0);
    chk({tag, ".mem_valid"}, mem_req_valid, 0);
    chk({tag, ".mem_addr"},  mem_addr, 0);
    chk({tag, ".mem_wen"},   mem_wen, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".mem_wmask"}, mem_wmask, 0);
  endtask

  // One minimum-latency read transaction starting in IDLE with requests already driven.
  // drop[0]/drop[1] release the IFU/LSU valid right after the accept edge.
  task automatic txn(input string tag, input bit exp_lsu, input logic [DW-1:0] rd, input bit [1:0] drop);
    #1;
    chk({tag, ".lsu_ready"}, lsu_req_ready, exp_lsu);
    chk({tag, ".ifu_ready"}, ifu_req_ready, !exp_lsu);
    tick();
    if (drop[0]) ifu_req_valid = 1'b0;
    if (drop[1]) lsu_req_valid = 1'b0;
    chk({tag, ".req_valid"}, mem_req_valid, 1);
    chk({tag, ".req_addr"},  mem_addr, exp_lsu ? lsu_addr : ifu_addr);
    chk({tag, ".req_wen"},   mem_wen, 0);
    chk({tag, ".req_wmask"}, mem_wmask, 0);
    chk({tag, ".busy_rdy"},  ifu_req_ready | lsu_req_ready, 0);
    tick();
    chk({tag, ".wait_valid"}, mem_req_valid, 0);
    mem_resp_valid = 1'b1;
    mem_rdata      = rd;
    tick();
    mem_resp_valid = 1'b0;
    chk({tag, ".lsu_resp"}, lsu_resp_valid, exp_lsu);
    chk({tag, ".ifu_resp"}, ifu_resp_valid, !exp_lsu);
    chk({tag, ".rdata"},    exp_lsu ? lsu_rdata : ifu_rdata, rd);
    tick();
    chk({tag, ".resp_done"}, ifu_resp_valid | lsu_resp_valid, 0);
  endtask

  initial begin
    rst = 1'b0;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    #2;
    chk_all_zero("reset");
    tick(); tick();
    rst = 1'b1;

    // Simultaneous requests
    ifu_addr = 32'h8000_0004; lsu_addr = 32'h8000_2000; lsu_wen = 0;
    ifu_req_valid = 1; lsu_req_valid = 1; mem_req_ready = 1;
`ifdef ARB_RR_EN
    txn("rr0_lsu", 1, 32'hA5A5_0001, 2'b00);
    txn("rr1_ifu", 0, 32'h0000_0013, 2'b00);
    txn("rr2_lsu", 1, 32'hA5A5_0002, 2'b00);
    txn("rr3_ifu", 0, 32'h0000_0093, 2'b11);
    lsu_req_valid = 0;
`else
    txn("tie_lsu", 1, 32'hA5A5_0001, 2'b10);
    txn("tie_ifu", 0, 32'h0000_0013, 2'b01);
`endif

    // IFU read at minimum latency
    ifu_addr = 32'h8000_0000; ifu_req_valid = 1; mem_req_ready = 1;
    #1;
    chk("ifu.ready", ifu_req_ready, 1);
    chk("ifu.lsu_ready", lsu_req_ready, 0);
    tick();
    ifu_req_valid = 0; ifu_addr = 32'h1234_5678;
    chk("ifu.req_valid", mem_req_valid, 1);
    chk("ifu.req_addr", mem_addr, 32'h8000_0000);
    chk("ifu.req_wen", mem_wen, 0);
    tick();
    chk("ifu.wait_resp", ifu_resp_valid, 0);
    mem_resp_valid = 1; mem_rdata = 32'h0010_0073;
    tick();
    mem_resp_valid = 0;
    chk("ifu.resp", ifu_resp_valid, 1);
    chk("ifu.rdata", ifu_rdata, 32'h0010_0073);
    chk("ifu.lsu_resp", lsu_resp_valid, 0);
    tick();
    chk("ifu.resp_pulse", ifu_resp_valid, 0);
    chk("ifu.rdata_hold", ifu_rdata, 32'h0010_0073);

    // LSU write with a stalled memory, stray resp_valid while in REQ
    lsu_addr = 32'h8000_1000; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    lsu_req_valid = 1; mem_req_ready = 0;
    #1;
    chk("wr.ready", lsu_req_ready, 1);
    tick();
    lsu_req_valid = 0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wmask = 4'h0; lsu_wen = 0;
    mem_resp_valid = 1; mem_rdata = 32'hBAD0_BAD0;
    for (int c = 0; c < 3; c++) begin
      chk("wr.req_valid", mem_req_valid, 1);
      chk("wr.req_addr",  mem_addr, 32'h8000_1000);
      chk("wr.req_wen",   mem_wen, 1);
      chk("wr.req_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("wr.req_wmask", mem_wmask, 4'hF);
      chk("wr.no_resp",   lsu_resp_valid, 0);
      if (c == 2) begin
        mem_req_ready = 1; mem_resp_valid = 0;
      end
      tick();
    end
    mem_req_ready = 0;
    chk("wr.wait_valid", mem_req_valid, 0);
    tick();
    chk("wr.wait_hold", lsu_resp_valid, 0);
    mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_resp_valid = 0;
    chk("wr.resp", lsu_resp_valid, 1);
    chk("wr.rdata", lsu_rdata, 32'h1234_5678);
    chk("wr.ifu_resp", ifu_resp_valid, 0);
    chk("wr.ifu_rdata_hold", ifu_rdata, 32'h0010_0073);
    tick();
    chk("wr.resp_pulse", lsu_resp_valid, 0);

    // Reset while waiting on memory, then a late response
    ifu_addr = 32'h8000_0008; ifu_req_valid = 1; mem_req_ready = 1;
    tick();
    ifu_req_valid = 0;
    tick();
    rst = 0;
    #1;
    chk_all_zero("rst_async");
    tick();
    chk_all_zero("rst_held");
    rst = 1;
    mem_resp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("late.ifu_resp", ifu_resp_valid, 0);
    chk("late.lsu_resp", lsu_resp_valid, 0);
    chk("late.mem_valid", mem_req_valid, 0);
    tick();
    chk("late.ifu_resp2", ifu_resp_valid, 0);
    chk("late.ifu_rdata", ifu_rdata, 0);
    mem_resp_valid = 0;
    lsu_req_valid = 1; lsu_addr = 32'h8000_3000;
    #1;
    chk("late.idle_ready", lsu_req_ready, 1);
    lsu_req_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU) in the npc core.
- Handles a single outstanding transaction at a time, using valid/ready request handshakes and variable-latency responses.
- Sits between the core and the memory access wrapper, so the pipeline can move from combinational memory reads to multi-cycle memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MASK_W, DATA_W/8, byte write-mask width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
ifu_req_valid  input  1  IFU read request
ifu_req_ready  output  1  IFU request accepted this cycle
ifu_addr  input  ADDR_W  IFU read address
ifu_resp_valid  output  1  one-cycle pulse: ifu_rdata valid
ifu_rdata  output  DATA_W  fetched instruction
lsu_req_valid  input  1  LSU request
lsu_req_ready  output  1  LSU request accepted this cycle
lsu_addr  input  ADDR_W  LSU address
lsu_wen  input  1  1 = write, 0 = read
lsu_wdata  input  DATA_W  store data
lsu_wmask  input  MASK_W  store byte mask
lsu_resp_valid  output  1  one-cycle pulse: LSU access complete
lsu_rdata  output  DATA_W  load data (write: whatever memory returns)
mem_req_valid  output  1  request to memory
mem_req_ready  input  1  memory accepts request
mem_addr  output  ADDR_W  registered address
mem_wen  output  1  registered write enable
mem_wdata  output  DATA_W  registered write data
mem_wmask  output  MASK_W  registered mask (0 on reads)
mem_resp_valid  input  1  memory response valid
mem_rdata  input  DATA_W  memory response data

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- Reset values: all outputs 0; owner = IFU; rr pointer = IFU.
- IDLE: the ready line of the selected requester equals 1; the other ready is 0. Ready is 0 in every state except IDLE.
- Selection is fixed priority: LSU beats IFU when both are valid.
- Accept condition: valid && ready in IDLE. On accept, register addr/wen/wdata/wmask (IFU: wen=0, wmask=0), record owner, go to REQ.
- IDLE with no valid request: stay in IDLE.
- REQ: mem_req_valid=1 with stable registered fields. Stay in REQ until mem_req_ready=1, then go to WAIT.
- WAIT: on mem_resp_valid=1, latch mem_rdata into the owner's rdata register and go to RESP.
- mem_resp_valid is ignored in IDLE, REQ and RESP.
- RESP: owner's resp_valid=1 for exactly one cycle, then go to IDLE.
- Non-owner resp_valid always 0. rdata registers hold their value until the next response.
- Responses have no backpressure; the requester must take them in the RESP cycle.
- Minimum latency (mem_req_ready=1 in REQ, mem_resp_valid=1 in the first WAIT cycle): resp_valid is seen 3 cycles after the accept edge, so the next accept is possible 4 cycles after the previous one.
- Request inputs may change or drop after acceptance; the registered copy is used.
- Reset asserted mid-transaction: FSM goes to IDLE immediately (asynchronous) and outputs go to 0. The in-flight access is dropped with no resp_valid. A late mem_resp_valid after reset release is ignored.

Optional Feature:
- Macro ARB_RR_EN. When defined, selection is round-robin: on simultaneous valid, the requester that is not the last-granted one wins.
- The pointer updates on each accept. Reset pointer = IFU, so the LSU wins the first tie.
- A single valid requester always wins.
- When not defined, fixed LSU priority applies and the pointer logic is absent.

Test Plan:
- IFU read addr 0x80000000, mem_req_ready=1, mem_resp_valid in the first WAIT cycle with data 0x00100073 -> mem_req_valid one cycle after accept with mem_addr 0x80000000, mem_wen 0; ifu_resp_valid pulses 3 cycles after accept with ifu_rdata 0x00100073; lsu_resp_valid stays 0.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready low 2 cycles -> mem_req_valid held 3 cycles with stable fields; lsu_resp_valid pulses once after mem_resp_valid.
- IFU and LSU valid in the same cycle, fixed priority -> LSU accepted first, IFU accepted in the IDLE after LSU's RESP.
- Same as above with ARB_RR_EN, both held valid continuously -> grants alternate LSU, IFU, LSU, IFU.
- rst driven to 0 while in WAIT, released, then stray mem_resp_valid=1 -> no resp_valid, FSM in IDLE, all outputs 0 during reset.
- mem_resp_valid=1 while in REQ -> ignored, no response until WAIT sees mem_resp_valid.
